// File: rtl/ecs_pkg.sv
// Shared helpers for the electrochemical workstation datapath.
// Width derivation and tap clamping reused by tap-selectable blocks.
package ecs_pkg;

    // Bits needed to hold any value 0..depth inclusive.
    function automatic int unsigned tap_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Map a raw tap request onto the legal range 1..depth.
    function automatic int unsigned clamp_tap(
        input int unsigned sel,
        input int unsigned depth
    );
        if (sel == 0)
            return 1;
        if (sel > depth)
            return depth;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One delay-line stage: data plus valid flag, with enable and
// synchronous clear back to the reset value.
module pipe_stage #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/delay_pipe.sv
// Programmable-length delay line with per-stage valid, flush,
// fill tracking and a combinational output tap.
module delay_pipe
    import ecs_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      TAP_W     = tap_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             primed,
    output logic [TAP_W-1:0] fill_cnt
);

    localparam logic [TAP_W-1:0] FILL_MAX = TAP_W'(DEPTH);

    logic [WIDTH-1:0] data  [DEPTH];
    logic             valid [DEPTH];
    logic [TAP_W-1:0] tap_eff;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (k == 0) begin : g_head
            assign d_in = din;
            assign v_in = din_valid;
        end else begin : g_link
            assign d_in = data[k-1];
            assign v_in = valid[k-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush),
            .en      (en),
            .d       (d_in),
            .d_valid (v_in),
            .q       (data[k]),
            .q_valid (valid[k])
        );
    end

    // Counts enabled shifts, not valid entries; saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush)
            fill_cnt <= '0;
        else if (en && (fill_cnt != FILL_MAX))
            fill_cnt <= fill_cnt + TAP_W'(1);
    end

    always_comb begin
        tap_eff = TAP_W'(clamp_tap(32'(tap_sel), DEPTH));
    end

    // Tap t selects stage t-1; clamp guarantees exactly one hit.
    always_comb begin
        dout       = RESET_VAL;
        dout_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_eff == TAP_W'(k + 1)) begin
                dout       = data[k];
                dout_valid = valid[k];
            end
        end
    end

    assign primed = (fill_cnt >= tap_eff);

endmodule

// File: tb/tb_delay_pipe.sv
// Randomised and directed bench for delay_pipe against a
// history-queue model of the delay line.
module tb_delay_pipe;

    localparam int          W    = 8;
    localparam int          D    = 4;
    localparam logic [7:0]  RV   = 8'hA5;
    localparam int          TW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic [TW-1:0] tap_sel = 3'd1;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          primed;
    logic [TW-1:0] fill_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    logic [W:0] hist[$];

    delay_pipe #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .din_valid  (din_valid),
        .tap_sel    (tap_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .primed     (primed),
        .fill_cnt   (fill_cnt)
    );

    always #5 clk = ~clk;

    // Model: the last D enabled pushes since the last clear.
    always @(posedge clk) begin
        if (rst || flush) begin
            hist.delete();
        end else if (en) begin
            hist.push_back({din, din_valid});
            if (hist.size() > D)
                void'(hist.pop_front());
        end
    end

    function automatic int eff_tap(input int sel);
        if (sel == 0) return 1;
        if (sel > D) return D;
        return sel;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            int t;
            int n;
            logic [W:0] e;
            t = eff_tap(int'(tap_sel));
            n = hist.size();
            e = (n >= t) ? hist[n-t] : {RV, 1'b0};
            chk("cyc_dout", 32'(dout), 32'(e[W:1]));
            chk("cyc_valid", 32'(dout_valid), 32'(e[0]));
            chk("cyc_primed", 32'(primed), 32'(n >= t));
            chk("cyc_fill", 32'(fill_cnt), 32'(n));
        end
    end

    task automatic step(input logic e, input logic f,
                        input logic [W-1:0] d, input logic v);
        en = e;
        flush = f;
        din = d;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_dout", 32'(dout), 32'h0A5);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_primed", 32'(primed), 32'h0);
        chk("rst_fill", 32'(fill_cnt), 32'h0);

        // Fixed latency at tap 3.
        tap_sel = 3'd3;
        step(1'b1, 1'b0, 8'd1, 1'b1);
        chk("lat1_dout", 32'(dout), 32'h0A5);
        chk("lat1_fill", 32'(fill_cnt), 32'd1);
        step(1'b1, 1'b0, 8'd2, 1'b1);
        chk("lat2_primed", 32'(primed), 32'h0);
        step(1'b1, 1'b0, 8'd3, 1'b1);
        chk("lat3_dout", 32'(dout), 32'd1);
        chk("lat3_valid", 32'(dout_valid), 32'h1);
        chk("lat3_primed", 32'(primed), 32'h1);
        step(1'b1, 1'b0, 8'd4, 1'b1);
        step(1'b1, 1'b0, 8'd5, 1'b1);
        step(1'b1, 1'b0, 8'd6, 1'b1);
        chk("sat_fill", 32'(fill_cnt), 32'd4);
        chk("lat6_dout", 32'(dout), 32'd4);

        // Enable gaps at tap 2.
        tap_sel = 3'd2;
        #1;
        chk("gap_tapsw", 32'(dout), 32'd5);
        step(1'b1, 1'b0, 8'h10, 1'b1);
        chk("gap_e1", 32'(dout), 32'd6);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'hEE, 1'b0);
            chk("gap_hold", 32'(dout), 32'd6);
        end
        step(1'b1, 1'b0, 8'h11, 1'b1);
        chk("gap_e2", 32'(dout), 32'h10);
        chk("gap_fill", 32'(fill_cnt), 32'd4);

        // Flush beats enable; FF never enters.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("fl_dout", 32'(dout), 32'h0A5);
        chk("fl_valid", 32'(dout_valid), 32'h0);
        chk("fl_fill", 32'(fill_cnt), 32'h0);
        chk("fl_primed", 32'(primed), 32'h0);
        tap_sel = 3'd1;
        #1;
        chk("fl_s0", 32'(dout), 32'h0A5);

        // Tap clamp and switching.
        step(1'b1, 1'b0, 8'h21, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h23, 1'b1);
        step(1'b1, 1'b0, 8'h24, 1'b1);
        en = 1'b0;
        tap_sel = 3'd0;
        #1;
        chk("tap0", 32'(dout), 32'h24);
        tap_sel = 3'd7;
        #1;
        chk("tap7", 32'(dout), 32'h21);
        chk("tap7_primed", 32'(primed), 32'h1);
        tap_sel = 3'd4;
        #1;
        chk("tap4", 32'(dout), 32'h21);
        tap_sel = 3'd1;
        #1;
        chk("tap1", 32'(dout), 32'h24);
        chk("tap1_primed", 32'(primed), 32'h1);

        // Bubbles at tap 2.
        tap_sel = 3'd2;
        step(1'b1, 1'b0, 8'h31, 1'b1);
        chk("bub0", 32'(dout), 32'h24);
        step(1'b1, 1'b0, 8'h32, 1'b0);
        chk("bub1_d", 32'(dout), 32'h31);
        chk("bub1_v", 32'(dout_valid), 32'h1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        chk("bub2_d", 32'(dout), 32'h32);
        chk("bub2_v", 32'(dout_valid), 32'h0);
        step(1'b1, 1'b0, 8'h34, 1'b1);
        chk("bub3_d", 32'(dout), 32'h33);
        chk("bub3_v", 32'(dout_valid), 32'h1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            tap_sel = TW'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) < 2);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < 4,
                 W'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_pipe.md
# delay_pipe

Parametrised synchronous delay line for the electrochemical workstation datapath: a chain of DEPTH registered stages of WIDTH bits with per-stage valid tracking, clock enable, flush and a runtime-selectable output tap. Replaces hand-chained plain flops wherever ADC samples, DAC codes or control strobes must be aligned by a programmable number of cycles. A fill counter flags when the selected tap holds data written since the last reset/flush.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of stages (>=1)
- RESET_VAL, {WIDTH{1'b0}}, data value loaded into every stage on rst/flush
- TAP_W, $clog2(DEPTH+1), tap_sel / fill_cnt width (derived, not overridden)

- clk  in  1  single system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  advance enable; chain shifts only when high
- flush  in  1  synchronous clear of contents and fill count
- din  in  WIDTH  input data
- din_valid  in  1  input qualifier
- tap_sel  in  TAP_W  selected delay, 1..DEPTH (clamped)
- dout  out  WIDTH  data at selected tap
- dout_valid  out  1  valid bit at selected tap
- primed  out  1  fill_cnt >= effective tap
- fill_cnt  out  TAP_W  shifts since rst/flush, saturating at DEPTH

## Operation
- Stages s[0..DEPTH-1], each {data, valid}.
- Priority per edge: rst > flush > en > hold.
- rst or flush: all s[k].data <= RESET_VAL, s[k].valid <= 0, fill_cnt <= 0.
- en=1: s[0] <= {din, din_valid}; s[k] <= s[k-1] for k=1..DEPTH-1; fill_cnt <= min(fill_cnt+1, DEPTH).
- en=0: everything holds; din/din_valid ignored.
- Effective tap t = 1 if tap_sel==0; DEPTH if tap_sel>DEPTH; else tap_sel.
- dout = s[t-1].data, dout_valid = s[t-1].valid; combinational mux from stage registers, no output register.
- primed = (fill_cnt >= t); combinational.
- din_valid=0 entries propagate as bubbles; data still shifts (data not gated by valid).
- tap_sel change mid-stream: dout/dout_valid/primed reflect new tap in the same cycle; no contents disturbed.
- fill_cnt counts en cycles, not valid entries.

## Timing
- Reset values: dout=RESET_VAL, dout_valid=0, primed=0, fill_cnt=0, visible the cycle after the rst edge.
- Latency: with en=1 continuously, din presented in cycle n appears on dout in cycle n+t (t rising edges).
- With gaps in en, latency = t enabled edges; disabled cycles add wall-clock delay only.
- flush and en together: flush wins, din in that cycle is discarded.
- rst mid-operation: contents lost in one edge, no partial shift.
- fill_cnt saturation: at DEPTH, further en edges leave it at DEPTH; no wrap.
- DEPTH=1: t always 1, primed after first en edge.
- tap_sel is not registered; caller keeps it stable for glitch-free dout if needed.

## Structure
- Shared package ecs_pkg: clog2-based width helper and a tap-clamp function (reused by other tap-selectable blocks).
- One sub-module natural: pipe_stage (WIDTH+1-bit register with enable and synchronous clear to RESET_VAL/0), instantiated DEPTH times via generate.
- Top holds fill counter, clamp, and output mux.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5, rst high 2 cycles -> dout=8'hA5, dout_valid=0, primed=0, fill_cnt=0.
- Fixed latency: en=1, tap_sel=3, din=1,2,3,... valid=1 -> dout=1 with dout_valid=1 exactly 3 cycles after din=1; primed rises in same cycle; fill_cnt saturates at 4 and stays.
- Enable gaps: tap_sel=2, din=8'h10 then en=0 for 5 cycles -> dout holds previous value; 8'h10 appears after second enabled edge.
- Flush priority: full pipe, flush=1 with en=1, din=8'hFF -> next cycle all dout_valid=0, dout=RESET_VAL, fill_cnt=0; 8'hFF never appears.
- Tap clamp/switch: tap_sel=0 -> behaves as 1; tap_sel=7 -> behaves as 4; switching 4->1 mid-stream shows s[0] same cycle with primed=1.
- Bubbles: din_valid pattern 1,0,1 at tap 2 -> dout_valid 1,0,1 delayed 2 cycles, data still shifted.
